// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: requester/bank bus between datapath masters and the write arbiter.
// Optional REG_WRITE_LOCK_EN adds lock_mask and err.
interface reg_write_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 8,
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 3
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]  req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REGS-1:0]       reg_we;
  logic [WIDTH-1:0]          reg_wdata;
  logic [NUM_REQ-1:0]        done;
`ifdef REG_WRITE_LOCK_EN
  logic [NUM_REGS-1:0]       lock_mask;
  logic [NUM_REQ-1:0]        err;
  modport master (output req, req_addr, req_data, lock_mask, input gnt, reg_we, reg_wdata, done, err);
  modport slave  (input req, req_addr, req_data, lock_mask, output gnt, reg_we, reg_wdata, done, err);
`else
  modport master (output req, req_addr, req_data, input gnt, reg_we, reg_wdata, done);
  modport slave  (input req, req_addr, req_data, output gnt, reg_we, reg_wdata, done);
`endif
endinterface

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin single-write-per-cycle arbiter driving a shared register bank.
// Optional REG_WRITE_LOCK_EN: per-register lock mask; locked/out-of-range writes raise err.
module reg_write_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 8,
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 3
) (
  input  logic               clk,
  input  logic               Reset,
  reg_write_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic [PTR_W-1:0]    ptr_q, ptr_d, gidx, idx;
  logic [NUM_REGS-1:0] we_q, we_d, dec;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  logic [NUM_REQ-1:0]  done_q, done_d, gnt;
  logic [ADDR_W-1:0]   addr;
  logic                xfer, locked;
`ifdef REG_WRITE_LOCK_EN
  logic [NUM_REQ-1:0]  err_q, err_d;
  logic                hit;
`endif
  // first asserted request at or after ptr wins; a grant is itself a completed transfer
  always_comb begin
    gnt = '0;
    gidx = '0;
    idx = '0;
    xfer = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!xfer && bus.req[idx]) begin
        xfer = 1'b1;
        gidx = idx;
      end
    end
    if (xfer) gnt[gidx] = 1'b1;
  end
  always_comb begin
    addr = bus.req_addr[int'(gidx)*ADDR_W +: ADDR_W];
    dec = '0;
    for (int r = 0; r < NUM_REGS; r++) dec[r] = (int'(addr) == r);
`ifdef REG_WRITE_LOCK_EN
    hit = |dec;
    locked = |(dec & bus.lock_mask);
    err_d = (!hit || locked) ? gnt : '0;
`else
    locked = 1'b0;
`endif
    we_d = (xfer && !locked) ? dec : '0;
    wdata_d = xfer ? bus.req_data[int'(gidx)*WIDTH +: WIDTH] : wdata_q;
    done_d = gnt;
    ptr_d = !xfer ? ptr_q : (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
  end
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      ptr_q <= '0;
      we_q <= '0;
      wdata_q <= '0;
      done_q <= '0;
`ifdef REG_WRITE_LOCK_EN
      err_q <= '0;
`endif
    end else begin
      ptr_q <= ptr_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      done_q <= done_d;
`ifdef REG_WRITE_LOCK_EN
      err_q <= err_d;
`endif
    end
  end
  assign bus.gnt = gnt;
  assign bus.reg_we = we_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.done = done_q;
`ifdef REG_WRITE_LOCK_EN
  assign bus.err = err_q;
`endif
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed vectors for the write arbiter plus a behavioural register bank.
module tb_reg_write_arbiter;
  localparam int NQ = 4, NR = 8, W = 32, AW = 3;
  localparam logic [NQ-1:0][AW-1:0] A1 = {3'd7, 3'd5, 3'd2, 3'd3};
  localparam logic [NQ-1:0][AW-1:0] A2 = {3'd2, 3'd5, 3'd2, 3'd3};
  localparam logic [NQ-1:0][AW-1:0] A3 = {3'd7, 3'd5, 3'd2, 3'd7};
  localparam logic [NQ-1:0][AW-1:0] A4 = {3'd7, 3'd0, 3'd2, 3'd2};
  localparam logic [NQ-1:0][W-1:0]  D1 = {32'h33, 32'hDEADBEEF, 32'h11, 32'hA0};
  localparam logic [NQ-1:0][W-1:0]  D2 = {32'h33, 32'h77, 32'h11, 32'h99};
  logic clk = 1'b0;
  logic Reset = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] y [NR];
  always #5 clk = ~clk;
  reg_write_arbiter_if #(.NUM_REQ(NQ), .NUM_REGS(NR), .WIDTH(W), .ADDR_W(AW)) bus ();
  reg_write_arbiter_if #(.NUM_REQ(NQ), .NUM_REGS(6), .WIDTH(W), .ADDR_W(AW)) bus6 ();
  reg_write_arbiter #(.NUM_REQ(NQ), .NUM_REGS(NR), .WIDTH(W), .ADDR_W(AW)) dut (.clk(clk), .Reset(Reset), .bus(bus));
  reg_write_arbiter #(.NUM_REQ(NQ), .NUM_REGS(6), .WIDTH(W), .ADDR_W(AW)) dut6 (.clk(clk), .Reset(Reset), .bus(bus6));
  // register bank sharing the arbiter's reset
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) for (int r = 0; r < NR; r++) y[r] <= '0;
    else for (int r = 0; r < NR; r++) if (bus.reg_we[r]) y[r] <= bus.reg_wdata;
  end
  typedef struct {
    logic [NQ-1:0]         req;
    logic [NQ-1:0][AW-1:0] addr;
    logic [NQ-1:0]         gnt;
    logic [NR-1:0]         we;
    logic [W-1:0]          wdata;
  } vec_t;
  vec_t tv[$];
`ifdef REG_WRITE_LOCK_EN
  logic [NR-1:0] lm = '0;
`endif
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask
  task automatic drive(input logic [NQ-1:0] r, input logic [NQ-1:0][AW-1:0] a, input logic [NQ-1:0][W-1:0] d);
    bus.req = r;
    bus.req_addr = a;
    bus.req_data = d;
    bus6.req = r;
    bus6.req_addr = a;
    bus6.req_data = d;
`ifdef REG_WRITE_LOCK_EN
    bus.lock_mask = lm;
    bus6.lock_mask = lm[5:0];
`endif
  endtask
  task automatic add(input logic [NQ-1:0] r, input logic [NQ-1:0][AW-1:0] a, input logic [NQ-1:0] g,
                     input logic [NR-1:0] we, input logic [W-1:0] wd);
    vec_t v;
    v.req = r;
    v.addr = a;
    v.gnt = g;
    v.we = we;
    v.wdata = wd;
    tv.push_back(v);
  endtask
  task automatic run_vec(input int i);
    string s;
    s = $sformatf("v%0d", i);
    drive(tv[i].req, tv[i].addr, D1);
    #1;
    chk({s, "_gnt"}, 32'(bus.gnt), 32'(tv[i].gnt));
    @(posedge clk);
    #1;
    chk({s, "_we"}, 32'(bus.reg_we), 32'(tv[i].we));
    chk({s, "_wdata"}, bus.reg_wdata, tv[i].wdata);
    chk({s, "_done"}, 32'(bus.done), 32'(tv[i].gnt));
    chk({s, "_we6"}, 32'(bus6.reg_we), 32'(tv[i].we[5:0]));
    chk({s, "_done6"}, 32'(bus6.done), 32'(tv[i].gnt));
    chk({s, "_wdata6"}, bus6.reg_wdata, tv[i].wdata);
`ifdef REG_WRITE_LOCK_EN
    chk({s, "_err"}, 32'(bus.err), 32'h0);
`endif
  endtask
  initial begin
    add(4'b0000, A1, 4'b0000, 8'h00, 32'hA0);
    add(4'b0100, A1, 4'b0100, 8'h20, 32'hDEADBEEF);
    add(4'b1000, A1, 4'b1000, 8'h80, 32'h33);
    for (int k = 0; k < 2; k++) begin
      add(4'b1111, A1, 4'b0001, 8'h08, 32'hA0);
      add(4'b1111, A1, 4'b0010, 8'h04, 32'h11);
      add(4'b1111, A1, 4'b0100, 8'h20, 32'hDEADBEEF);
      add(4'b1111, A1, 4'b1000, 8'h80, 32'h33);
    end
    add(4'b1010, A2, 4'b0010, 8'h04, 32'h11);
    add(4'b1010, A2, 4'b1000, 8'h04, 32'h33);
    add(4'b0000, A2, 4'b0000, 8'h00, 32'h33);
    add(4'b0001, A3, 4'b0001, 8'h80, 32'hA0);
    add(4'b0011, A1, 4'b0010, 8'h04, 32'h11);
    add(4'b0011, A1, 4'b0001, 8'h08, 32'hA0);
    drive(4'b1111, A1, D1);
    #2;
    chk("rst_gnt", 32'(bus.gnt), 32'h1);
    @(posedge clk);
    #1;
    chk("rst_we", 32'(bus.reg_we), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_wdata", bus.reg_wdata, 32'h0);
    Reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_we", 32'(bus.reg_we), 32'h08);
    chk("rel_done", 32'(bus.done), 32'h1);
    chk("rel_wdata", bus.reg_wdata, 32'hA0);
    for (int i = 0; i < 3; i++) run_vec(i);
    chk("y5", y[5], 32'hDEADBEEF);
    for (int i = 3; i < 14; i++) run_vec(i);
    chk("y2_last_wins", y[2], 32'h33);
    for (int i = 14; i < tv.size(); i++) run_vec(i);
`ifdef REG_WRITE_LOCK_EN
    lm = 8'h04;
    drive(4'b0001, A4, D2);
    #1;
    chk("lock_gnt", 32'(bus.gnt), 32'h1);
    @(posedge clk);
    #1;
    chk("lock_we", 32'(bus.reg_we), 32'h0);
    chk("lock_done", 32'(bus.done), 32'h1);
    chk("lock_err", 32'(bus.err), 32'h1);
    lm = '0;
    drive(4'b0000, A4, D2);
    @(posedge clk);
    #1;
    chk("lock_y2", y[2], 32'h11);
`endif
    drive(4'b0100, A4, D2);
    @(posedge clk);
    #1;
    chk("pre_abort_we", 32'(bus.reg_we), 32'h01);
    #2;
    Reset = 1'b0;
    drive(4'b1111, A1, D1);
    #1;
    chk("abort_we", 32'(bus.reg_we), 32'h0);
    chk("abort_wdata", bus.reg_wdata, 32'h0);
    chk("abort_gnt", 32'(bus.gnt), 32'h1);
    chk("abort_y0", y[0], 32'h0);
    @(posedge clk);
    #1;
    chk("hold_we", 32'(bus.reg_we), 32'h0);
    chk("hold_done", 32'(bus.done), 32'h0);
    chk("hold_y0", y[0], 32'h0);
    Reset = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write arbiter that shares one bank of NUM_REGS 32-bit registers (`nBitRegister`-style cells with `WE`, `nBitIn`, `clk`, `Reset`) among NUM_REQ requesters. At most one write is granted per cycle. The granted address is decoded into a one-hot per-register write enable, and the granted data is driven onto a shared write bus. The block sits between the datapath masters and the register bank and is the only driver of the bank's `WE` and `nBitIn` pins.

## Interface
- NUM_REQ, 4: number of requesters; 2..8.
- NUM_REGS, 8: registers in the bank; 2..16.
- WIDTH, 32: data width.
- ADDR_W, 3: register address width; 2**ADDR_W >= NUM_REGS.

- clk  in  1  single clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester write request (level).
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*WIDTH  packed data; requester i uses slice [i*WIDTH +: WIDTH].
- gnt  out  NUM_REQ  one-hot grant; combinational from `req` and the priority pointer.
- reg_we  out  NUM_REGS  registered one-hot write enable to the bank.
- reg_wdata  out  WIDTH  registered write data to the bank.
- done  out  NUM_REQ  registered one-cycle pulse to the requester whose write is issuing.

## Operation
- Priority pointer `ptr` (0..NUM_REQ-1):
  - The highest-priority requester is `ptr`, then `ptr+1`, and so on, wrapping modulo NUM_REQ.
  - `gnt[i]`=1 for exactly the first asserted `req` in that order. `gnt` is 0 when `req`=0.
- Handshake: a transfer completes at a rising edge where `req[i] & gnt[i]`.
  - The requester holds `req`, `req_addr` and `req_data` stable until that edge.
  - Keeping `req` high after completion requests another write; it re-arbitrates next cycle.
- On a completed transfer by requester i at edge k:
  - `ptr` <= (i+1) mod NUM_REQ.
  - `reg_we` <= one-hot(`req_addr[i]`).
  - `reg_wdata` <= `req_data[i]`.
  - `done[i]` <= 1.
- With no transfer at an edge: `reg_we`=0, `done`=0, `ptr` unchanged, `reg_wdata` holds its last value.
- Out-of-range address (`req_addr` >= NUM_REGS): the transfer completes and `done` pulses, but `reg_we` stays all-zero (dropped write).
- One write per cycle, so bank write collisions are impossible. Back-to-back writes to the same register from different requesters land in grant order; the last one wins.
- Reset low (any time, asynchronous):
  - `ptr`=0, `reg_we`=0, `reg_wdata`=0, `done`=0.
  - `gnt` follows `req` with `ptr`=0.
  - No handshake completes while Reset is low.
  - A write whose `reg_we` was high is aborted immediately. The bank is also being reset by the same Reset, so it ends at 0.

## Timing
- `gnt` is valid in the same cycle as `req`: combinational, no added latency.
- Transfer at edge k → `reg_we`/`reg_wdata`/`done` high during cycle k..k+1 → bank `Y` updates at edge k+1.
- Request-to-`Y` latency is 2 edges when uncontended. With all NUM_REQ requesting continuously, each waits at most NUM_REQ-1 cycles.
- Sustained throughput: 1 write/cycle.
- First rising edge after Reset deasserts may complete a transfer.

## Configuration
- `REG_WRITE_LOCK_EN` defined:
  - Adds input `lock_mask` [NUM_REGS] and output `err` [NUM_REQ] (registered, same timing as `done`).
  - A completed transfer to a locked address, or to an out-of-range address, gives `reg_we`=0, `done[i]`=1 and `err[i]`=1.
  - `err` resets to 0.
- `REG_WRITE_LOCK_EN` undefined:
  - `lock_mask` and `err` ports are absent.
  - Behaviour is exactly as in Operation.

## Test plan
- Reset low with `req`=4'b1111 → `gnt`=4'b0001, `reg_we`=0, `done`=0. After release, the first edge gives `reg_we`=one-hot(`req_addr[0]`) and `done`=4'b0001.
- Single requester 2 writes 0xDEADBEEF to addr 5 → `gnt`=4'b0100 in that cycle. Next cycle `reg_we`=8'h20 and `reg_wdata`=0xDEADBEEF. Bank `Y5`=0xDEADBEEF one edge later.
- All 4 requesters held high for 8 cycles → grant order 0,1,2,3,0,1,2,3; one `done` pulse per cycle.
- Requesters 1 and 3 write addr 2 with 0x11 and 0x33 simultaneously, `ptr`=0 → 1 granted first, then 3. Final `Y2`=0x33.
- Addr 7 with NUM_REGS=6 → `done` pulses and `reg_we`=0. With `REG_WRITE_LOCK_EN` and `lock_mask`[2]=1, a write to addr 2 also gives `err`=1 and `Y2` unchanged.
- Reset asserted mid-cycle while `reg_we`=8'h01 → `reg_we` drops to 0 immediately, `ptr`=0, and bank `Y0`=0.
